// File: rtl/keypad_bcd_encoder_if.sv
// Keypad-to-BCD bundle: raw keys in, accepted digit, strobe and status out.
// The master side drives the keys; the encoder sits on the slave side.
interface keypad_bcd_encoder_if;
  logic [9:0] keys;
  logic [3:0] bcd_out;
  logic       digit_valid;
  logic       multi_key;
  logic       busy;

  modport master (
    output keys,
    input  bcd_out,
    input  digit_valid,
    input  multi_key,
    input  busy
  );

  modport slave (
    input  keys,
    output bcd_out,
    output digit_valid,
    output multi_key,
    output busy
  );
endinterface

// File: rtl/keypad_bcd_encoder.sv
// Debounced 10-key decimal keypad encoder: synchronizes the raw keys, accepts one
// key after a stable window, emits its BCD code with a single-cycle strobe.
module keypad_bcd_encoder #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  keypad_bcd_encoder_if.slave  bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [9:0]       keys_meta_reg;
  logic [9:0]       keys_s_reg;
  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       cand_reg, cand_next;
  logic [3:0]       bcd_reg, bcd_next;
  logic             valid_reg, valid_next;
  logic             multi_reg, multi_next;

  logic [3:0] idx_terms [10];
  logic [3:0] key_idx;
  logic       key_any;
  logic       key_one;
  logic [9:0] cand_hot;

  // Each set key contributes its own digit code; only meaningful when one-hot.
  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_idx
      assign idx_terms[gi] = keys_s_reg[gi] ? 4'(gi) : 4'd0;
    end
  endgenerate

  always_comb begin
    key_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      key_idx = key_idx | idx_terms[i];
    end
  end

  assign key_any  = |keys_s_reg;
  assign key_one  = key_any && ((keys_s_reg & (keys_s_reg - 10'(1))) == 10'd0);
  assign cand_hot = 10'(1) << cand_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cand_next  = cand_reg;
    bcd_next   = bcd_reg;
    valid_next = 1'b0;
    multi_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (key_one) begin
          cand_next  = key_idx;
          cnt_next   = '0;
          state_next = DEBOUNCE;
        end else if (key_any) begin
          multi_next = 1'b1;
        end
      end
      DEBOUNCE: begin
        // Any deviation from the lone candidate key restarts from IDLE.
        if (keys_s_reg != cand_hot) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HELD;
          bcd_next   = cand_reg;
          valid_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      HELD: begin
        if (!key_any) begin
          cnt_next   = '0;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (key_any) begin
          state_next = HELD;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      keys_meta_reg <= '0;
      keys_s_reg    <= '0;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cand_reg      <= '0;
      bcd_reg       <= '0;
      valid_reg     <= 1'b0;
      multi_reg     <= 1'b0;
    end else begin
      keys_meta_reg <= bus.keys;
      keys_s_reg    <= keys_meta_reg;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cand_reg      <= cand_next;
      bcd_reg       <= bcd_next;
      valid_reg     <= valid_next;
      multi_reg     <= multi_next;
    end
  end

  assign bus.bcd_out     = bcd_reg;
  assign bus.digit_valid = valid_reg;
  assign bus.multi_key   = multi_reg;
  assign bus.busy        = (state_reg != IDLE);

endmodule

// File: doc/keypad_bcd_encoder.md
KEYPAD_BCD_ENCODER -- requirements
Module: keypad_bcd_encoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 8, integer >= 1; number of consecutive stable synchronized samples needed to accept a press or release.
REQ-002 The block SHALL have parameter CNT_W, default 16; debounce counter width, with 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 The block SHALL have port clk, input, 1 bit; single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-005 The block SHALL have port keys, input, 10 bits; raw asynchronous active-high buttons, keys[d] = decimal digit d.
REQ-006 The block SHALL have port bcd_out, output, 4 bits; last accepted digit, BCD 0000-1001, feeds the downstream BCD-to-binary stage.
REQ-007 The block SHALL have port digit_valid, output, 1 bit; one-cycle strobe marking a newly accepted digit.
REQ-008 The block SHALL have port multi_key, output, 1 bit; registered flag, high while idle with more than one synchronized key high.
REQ-009 The block SHALL have port busy, output, 1 bit; high whenever state is not IDLE.

Function
REQ-010 keys SHALL pass through a 2-flop synchronizer; all decisions use the second flop (keys_s).
REQ-011 The FSM SHALL have exactly four states: IDLE, DEBOUNCE, HELD, RELEASE; a debounce counter cnt[CNT_W-1:0] and a candidate register cand[3:0].
REQ-012 IDLE, keys_s == 0: stay; multi_key <= 0.
REQ-013 IDLE, exactly one bit d of keys_s high: cand <= d, cnt <= 0, go DEBOUNCE; multi_key <= 0.
REQ-014 IDLE, two or more bits high: stay IDLE, multi_key <= 1, no strobe.
REQ-015 DEBOUNCE, keys_s != one-hot(cand): go IDLE, cnt <= 0, no strobe (bounce or second key aborts).
REQ-016 DEBOUNCE, keys_s == one-hot(cand), cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
REQ-017 DEBOUNCE, keys_s == one-hot(cand), cnt == DEBOUNCE_CYCLES-1: go HELD, bcd_out <= cand, digit_valid <= 1.
REQ-018 digit_valid SHALL be high for exactly one cycle per accepted press; it is 0 in every other cycle.
REQ-019 Latency: with a single key applied and held stable from before edge t, digit_valid and the new bcd_out SHALL be visible after edge t+DEBOUNCE_CYCLES+2 (2 sync + 1 IDLE + DEBOUNCE_CYCLES-1 counting, edges counted from 0).
REQ-020 HELD, any bit of keys_s high (including extra keys): stay, no strobe; bcd_out unchanged.
REQ-021 HELD, keys_s == 0: cnt <= 0, go RELEASE.
REQ-022 RELEASE, any bit of keys_s high: go HELD (release bounce), no strobe.
REQ-023 RELEASE, keys_s == 0, cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1; at cnt == DEBOUNCE_CYCLES-1: go IDLE.
REQ-024 bcd_out SHALL hold its value until the next accepted press; it never takes a value above 1001.
REQ-025 A key held indefinitely SHALL produce exactly one strobe (no auto-repeat).
REQ-026 cnt SHALL never wrap; it is bounded by DEBOUNCE_CYCLES-1 in both counting states.
REQ-027 multi_key SHALL be 0 in every state other than IDLE.

Reset
REQ-028 While rst is high at a clock edge: state <= IDLE, synchronizer flops <= 0, cnt <= 0, cand <= 0, bcd_out <= 0000, digit_valid <= 0, multi_key <= 0, busy <= 0.
REQ-029 Reset asserted mid-DEBOUNCE or mid-HELD SHALL abort with no strobe; after release a still-held key is treated as a new press from IDLE.
REQ-030 rst SHALL take priority over every other condition in the same cycle.

Verification
REQ-031 DEBOUNCE_CYCLES=8, keys=0x020 held 20 cycles: exactly one digit_valid, after edge 10; bcd_out=0101; busy=1 until 8 idle samples after release.
REQ-032 keys=0x200 toggling every 3 cycles for 30 cycles, then stable: no strobe during toggling; one strobe with bcd_out=1001 after stable window.
REQ-033 keys=0x003 held: multi_key=1 from edge 3 onward, no strobe, bcd_out stays 0000; drop to 0x002: strobe with bcd_out=0001.
REQ-034 Press 0x004 until strobe, add 0x008 while held, release 0x004 only, then all: no second strobe, bcd_out=0010; next clean press 0x001 gives bcd_out=0000 strobe.
REQ-035 Press 0x080, assert rst for 1 cycle at cnt=4 in DEBOUNCE: no strobe, all outputs reset; key still held gives strobe bcd_out=0111 DEBOUNCE_CYCLES+3 edges after rst drops.
REQ-036 DEBOUNCE_CYCLES=1: stable single press 0x010 gives strobe after edge 3, bcd_out=0100.
